// File: rtl/pipe_carry_adder_if.sv
// Operand/result handshake bundle for pipe_carry_adder.
// master: drives operands and out_ready; slave: the adder.
interface pipe_carry_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, y, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, y, cout, ovf
  );
endinterface

// File: rtl/pipe_carry_adder_seg_adder.sv
// SEG-bit combinational ripple adder for one pipeline segment.
// Ports: a, b, cin in; y sum, cout carry out, cmsb carry into MSB.
module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] y,
  output logic           cout,
  output logic           cmsb
);
  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign y[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];
endmodule

// File: rtl/pipe_carry_adder.sv
// Carry-pipelined add/subtract, SEG bits resolved per stage.
// Ports: clk, rst (async high), io (slave): valid/ready operands
// a, b, cin, sub in; y, cout, ovf out with valid/ready.
module pipe_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic               clk,
  input logic               rst,
  pipe_carry_adder_if.slave io
);
  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0 ||
      STAGES < 1 || STAGES > 16) begin : g_chk
    $error("pipe_carry_adder: bad WIDTH/SEG");
  end

  logic stall;
  logic en;

  // stage inputs (combinational) and stage registers
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] iy [STAGES];
  logic [WIDTH-1:0] ny [STAGES];
  logic             ic [STAGES];
  logic             iv [STAGES];
  logic [SEG-1:0]   sy [STAGES];
  logic             co [STAGES];
  logic             cm [STAGES];

  logic [WIDTH-1:0] ra  [STAGES];
  logic [WIDTH-1:0] rb  [STAGES];
  logic [WIDTH-1:0] ry  [STAGES];
  logic             rc  [STAGES];
  logic             vld [STAGES];
  logic             rovf;

  // whole pipe advances unless the output is blocked;
  // bubbles move with it so they never cause a stall
  assign stall       = vld[STAGES-1] & ~io.out_ready;
  assign en          = ~stall;
  assign io.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // subtract is a + ~b + ~cin
      assign ia[k] = io.a;
      assign ib[k] = io.sub ? ~io.b : io.b;
      assign ic[k] = io.cin ^ io.sub;
      assign iy[k] = '0;
      assign iv[k] = io.in_valid;
    end else begin : g_body
      assign ia[k] = ra[k-1];
      assign ib[k] = rb[k-1];
      assign ic[k] = rc[k-1];
      assign iy[k] = ry[k-1];
      assign iv[k] = vld[k-1];
    end

    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .a    (ia[k][k*SEG +: SEG]),
      .b    (ib[k][k*SEG +: SEG]),
      .cin  (ic[k]),
      .y    (sy[k]),
      .cout (co[k]),
      .cmsb (cm[k])
    );

    // splice this stage's segment into the partial result
    for (genvar j = 0; j < STAGES; j++) begin : g_seg
      if (j == k) begin : g_new
        assign ny[k][j*SEG +: SEG] = sy[k];
      end else begin : g_old
        assign ny[k][j*SEG +: SEG] = iy[k][j*SEG +: SEG];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        ra[k]  <= '0;
        rb[k]  <= '0;
        ry[k]  <= '0;
        rc[k]  <= 1'b0;
      end
      rovf <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= iv[k];
        ra[k]  <= ia[k];
        rb[k]  <= ib[k];
        ry[k]  <= ny[k];
        rc[k]  <= co[k];
      end
      rovf <= cm[STAGES-1] ^ co[STAGES-1];
    end
  end

  assign io.out_valid = vld[STAGES-1];
  assign io.y         = ry[STAGES-1];
  assign io.cout      = rc[STAGES-1];
  assign io.ovf       = rovf;
endmodule

// File: tb/tb_pipe_carry_adder.sv
// Self-checking bench for pipe_carry_adder (WIDTH=16, SEG=4).
// Arithmetic reference model plus handshake scoreboard queue.
module tb_pipe_carry_adder;
  localparam int W = 16;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_carry_adder_if #(.WIDTH(W)) io ();

  pipe_carry_adder #(
    .WIDTH (W),
    .SEG   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int tests = 0;
  int fails = 0;

  // {cout, ovf, y}
  logic [17:0] q[$];

  function automatic logic [17:0] model(
    input logic [15:0] a, input logic [15:0] b,
    input logic ci, input logic sb
  );
    int r;
    int s;
    logic cy;
    if (sb) begin
      r  = int'(a) - int'(b) - int'(ci);
      s  = int'($signed(a)) - int'($signed(b)) - int'(ci);
      cy = (r >= 0);
    end else begin
      r  = int'(a) + int'(b) + int'(ci);
      s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      cy = (r > 65535);
    end
    return {cy, (s < -32768 || s > 32767), r[15:0]};
  endfunction

  task automatic drive(
    input logic v, input logic [15:0] a_, input logic [15:0] b_,
    input logic ci, input logic sb
  );
    io.in_valid = v;
    io.a        = a_;
    io.b        = b_;
    io.cin      = ci;
    io.sub      = sb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (io.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", io.out_valid);
    end
    tests++;
    if (io.y !== 16'h0) begin
      fails++; $display("FAIL reset_y got %h want 0000", io.y);
    end
    tests++;
    if ({io.cout, io.ovf} !== 2'b00) begin
      fails++; $display("FAIL reset_flags got %b%b want 00", io.cout, io.ovf);
    end
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", io.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    io.out_ready = 1'b1;
    #1;
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_in_ready got %b want 1", io.in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] ta [6] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000, 16'h0005};
    logic [15:0] tb [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'h0005};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [17:0] te [6] = '{{2'b10, 16'h0000}, {2'b01, 16'h8000},
                            {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                            {2'b00, 16'h0001}, {2'b00, 16'hFFFF}};
    for (int i = 0; i < 6; i++) begin
      int lat;
      logic [17:0] got;
      lat = 0;
      got = '0;
      @(negedge clk);
      io.out_ready = 1'b1;
      drive(1'b1, ta[i], tb[i], tc[i], ts[i]);
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        if (io.out_valid) begin
          lat = c;
          got = {io.cout, io.ovf, io.y};
        end
      end
      tests++;
      if (lat != LAT) begin
        fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, LAT);
      end
      tests++;
      if (got !== te[i]) begin
        fails++;
        $display("FAIL vec%0d_result got %h want %h", i, got, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nout;
    nout = 0;
    q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      io.out_ready = 1'b1;
      if (cyc < 4)
        drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (io.out_valid && io.out_ready) begin
        logic [17:0] exp;
        exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        tests++;
        if ({io.cout, io.ovf, io.y} !== exp) begin
          fails++;
          $display("FAIL b2b_result got %h want %h", {io.cout, io.ovf, io.y}, exp);
        end
        tests++;
        if (cyc != LAT + nout) begin
          fails++; $display("FAIL b2b_cycle got %0d want %0d", cyc, LAT + nout);
        end
        nout++;
      end
      if (io.in_valid && io.in_ready)
        q.push_back(model(io.a, io.b, io.cin, io.sub));
    end
    tests++;
    if (nout != 4) begin
      fails++; $display("FAIL b2b_count got %0d want 4", nout);
    end
  endtask

  task automatic test_stall();
    int sent;
    int got;
    logic newb;
    logic [15:0] ca, cb;
    logic cc, cs;
    logic [15:0] held;
    sent = 0;
    got  = 0;
    newb = 1'b1;
    held = '0;
    ca = '0; cb = '0; cc = 1'b0; cs = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      io.out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 6) begin
        if (newb) begin
          ca = 16'($urandom); cb = 16'($urandom);
          cc = 1'($urandom);  cs = 1'($urandom);
          newb = 1'b0;
        end
        drive(1'b1, ca, cb, cc, cs);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end
      #1;
      if (cyc == 4) held = io.y;
      if (cyc >= 4 && cyc <= 6) begin
        tests++;
        if (io.in_ready !== 1'b0) begin
          fails++; $display("FAIL stall_in_ready c%0d got %b want 0", cyc, io.in_ready);
        end
        tests++;
        if (io.out_valid !== 1'b1 || io.y !== held) begin
          fails++;
          $display("FAIL stall_hold c%0d got %b/%h want 1/%h", cyc, io.out_valid, io.y, held);
        end
      end
      if (io.out_valid && io.out_ready) begin
        logic [17:0] exp;
        exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        tests++;
        if ({io.cout, io.ovf, io.y} !== exp) begin
          fails++;
          $display("FAIL stall_result got %h want %h", {io.cout, io.ovf, io.y}, exp);
        end
        got++;
      end
      if (io.in_valid && io.in_ready) begin
        q.push_back(model(io.a, io.b, io.cin, io.sub));
        sent++;
        newb = 1'b1;
      end
    end
    tests++;
    if (got != 6) begin
      fails++; $display("FAIL stall_count got %0d want 6", got);
    end
  endtask

  task automatic test_random();
    logic pstall;
    logic [17:0] prev;
    pstall = 1'b0;
    prev   = '0;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      io.out_ready = ($urandom_range(0, 9) < 7);
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      #1;
      tests++;
      if (io.in_ready !== !(io.out_valid && !io.out_ready)) begin
        fails++;
        $display("FAIL rnd_in_ready got %b want %b", io.in_ready,
                 !(io.out_valid && !io.out_ready));
      end
      if (pstall) begin
        tests++;
        if ({io.cout, io.ovf, io.y} !== prev || io.out_valid !== 1'b1) begin
          fails++;
          $display("FAIL rnd_hold got %h want %h", {io.cout, io.ovf, io.y}, prev);
        end
      end
      pstall = io.out_valid && !io.out_ready;
      prev   = {io.cout, io.ovf, io.y};
      if (io.out_valid && io.out_ready) begin
        logic [17:0] exp;
        exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        tests++;
        if ({io.cout, io.ovf, io.y} !== exp) begin
          fails++;
          $display("FAIL rnd_result got %h want %h", {io.cout, io.ovf, io.y}, exp);
        end
      end
      if (io.in_valid && io.in_ready)
        q.push_back(model(io.a, io.b, io.cin, io.sub));
    end
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      @(negedge clk);
      io.out_ready = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (io.out_valid) begin
        logic [17:0] exp;
        exp = q.pop_front();
        tests++;
        if ({io.cout, io.ovf, io.y} !== exp) begin
          fails++;
          $display("FAIL drain_result got %h want %h", {io.cout, io.ovf, io.y}, exp);
        end
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL drain_left got %0d want 0", q.size());
    end
  endtask

  task automatic test_reset_flight();
    int stale;
    int lat;
    logic [17:0] exp;
    logic [17:0] got;
    stale = 0;
    lat   = 0;
    got   = '0;
    q.delete();
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc < 3)
        drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    #1;
    tests++;
    if (io.out_valid !== 1'b1) begin
      fails++; $display("FAIL flight_valid got %b want 1", io.out_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({io.out_valid, io.cout, io.ovf} !== 3'b000 || io.y !== 16'h0) begin
      fails++;
      $display("FAIL rst_async got v%b c%b o%b y%h want 0 0 0 0000",
               io.out_valid, io.cout, io.ovf, io.y);
    end
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_in_ready got %b want 1", io.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1;
      if (io.out_valid) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++; $display("FAIL rst_stale got %0d want 0", stale);
    end
    @(negedge clk);
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    exp = model(io.a, io.b, io.cin, io.sub);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (io.out_valid) begin
        lat = c;
        got = {io.cout, io.ovf, io.y};
      end
    end
    tests++;
    if (lat != LAT) begin
      fails++; $display("FAIL post_rst_latency got %0d want %0d", lat, LAT);
    end
    tests++;
    if (got !== exp) begin
      fails++; $display("FAIL post_rst_result got %h want %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_carry_adder.md
PIPE_CARRY_ADDER -- requirements
Module: pipe_carry_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter SEG, default 4, bits added per pipeline stage.
REQ-003 WIDTH SHALL be a nonzero multiple of SEG; derived STAGES = WIDTH/SEG, legal 1..16.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry/borrow in.
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 cout  output  1  raw carry out of MSB.
REQ-016 ovf  output  1  two's-complement overflow.

Function
REQ-017 Effective B SHALL be b when sub=0, ~b when sub=1; stage-0 carry SHALL be cin XOR sub (add: A+B+cin; sub: A-B-cin).
REQ-018 Stage k (0..STAGES-1) SHALL add segment k of A and effective B plus stage k-1's registered carry; untouched upper segments SHALL be registered forward unchanged (operand skew).
REQ-019 Completed lower segments SHALL be registered forward so y assembles in stage STAGES-1's output register.
REQ-020 Each stage SHALL hold a valid bit; latency in_valid&in_ready -> out_valid = STAGES cycles with no stall.
REQ-021 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-022 Stall = out_valid & ~out_ready; while stalled, all stage registers SHALL hold and in_ready SHALL be 0.
REQ-023 in_ready SHALL be ~stall (combinational, no dependence on in_valid).
REQ-024 Bubbles (valid=0) SHALL advance without stalling; no beat dropped or duplicated.
REQ-025 y, cout, ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 cout SHALL be the carry out of bit WIDTH-1 (sub: cout=1 means no borrow).
REQ-027 ovf SHALL be carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-028 STAGES=1 SHALL degenerate to a single registered adder, latency 1.
REQ-029 Simultaneous output accept and input accept SHALL both occur in the same cycle.

Reset
REQ-030 rst=1 SHALL immediately clear all stage valid bits; out_valid=0, y=0, cout=0, ovf=0.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 Beats in flight at reset assertion SHALL be discarded; no output appears for them after release.
REQ-033 First beat accepted after release SHALL appear STAGES cycles later.

Structure
REQ-034 No shared package; STAGES SHALL be a localparam in the module.
REQ-035 One sub-module, seg_adder (SEG-bit combinational ripple adder: a, b, cin -> y, cout, plus carry into its MSB), instantiated once per stage via generate.
REQ-036 No combinational path SHALL run from a/b/cin/sub to y/cout/ovf.

Verification (WIDTH=16, SEG=4)
REQ-037 a=FFFF b=0001 cin=0 sub=0 -> 4 cycles later y=0000 cout=1 ovf=0.
REQ-038 a=7FFF b=0001 cin=0 sub=0 -> y=8000 cout=0 ovf=1.
REQ-039 a=0005 b=0007 cin=0 sub=1 -> y=FFFE cout=0 ovf=0; a=8000 b=0001 sub=1 -> y=7FFF ovf=1.
REQ-040 4 back-to-back beats, out_ready=1 -> 4 consecutive out_valid cycles, in order, correct sums.
REQ-041 out_ready=0 for 3 cycles with pipe full -> in_ready=0, y held; release -> all results in order, none lost.
REQ-042 rst pulsed with 3 beats in flight -> out_valid=0 at once, no stale results after release; the next beat is correct at latency 4.
